pipe_trace_buffer: RTL and testbench

Synthesizable, parametrised pipeline trace buffer that replaces fixed per-signal cycle printing for the processor. It samples up to NUM_CH pipeline taps (pc, o_xm, a_dx, alu_input_2, …) each cycle into a circular buffer. It freezes POST_TRIG samples after a trigger, or when a cycle limit expires. It sits beside the processor in the skeleton and is read back afterwards through an indexed read port.

---
 rtl/pipe_trace_buffer.sv | 148 ++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer.sv
// Circular trace buffer for pipeline taps: captures every cycle while armed, freezes POST_TRIG samples after a trigger or at CYCLE_LIMIT.
// Optional per-sample timestamps under `define TRACE_TIMESTAMP_EN; indexed read port with 1-cycle latency.
module pipe_trace_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 16,
    parameter int POST_TRIG   = 8,
    parameter int CYCLE_LIMIT = 20,
    parameter int CNT_WIDTH   = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PW = $clog2(DEPTH) + 1
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_arm,
    input  logic                         i_trig,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_data,
    input  logic [NUM_CH-1:0]            i_ch_mask,
    output logic [1:0]                   o_state,
    output logic                         o_done,
    output logic                         o_limit_hit,
    output logic [CNT_WIDTH-1:0]         o_cycle_count,
    output logic [AW:0]                  o_entries,
    input  logic                         i_rd_en,
    input  logic [AW-1:0]                i_rd_idx,
    input  logic [CW-1:0]                i_rd_ch,
    output logic [DATA_WIDTH-1:0]        o_rd_data,
    output logic [CNT_WIDTH-1:0]         o_rd_ts,
    output logic                         o_rd_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW:0]            r_entries;
    logic [CNT_WIDTH-1:0]   r_cycle_count;
    logic [PW-1:0]          r_post_cnt;
    logic                   r_limit_hit;
    logic [DATA_WIDTH-1:0]  r_rd_data;
    logic                   r_rd_valid;

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH][NUM_CH];

    logic                   w_capture;
    logic [CNT_WIDTH-1:0]   w_cnt_next;
    logic                   w_limit;
    logic [AW-1:0]          w_rd_slot;
    logic                   w_rd_ok;

    // arm wins over a capture in the same cycle: the buffer restarts empty
    assign w_capture  = !i_arm && (r_state == S_ARMED || r_state == S_POST);
    assign w_cnt_next = r_cycle_count + 1'b1;
    assign w_limit    = (CYCLE_LIMIT != 0) && (w_cnt_next == CNT_WIDTH'(CYCLE_LIMIT));
    assign w_rd_slot  = r_wr_ptr - r_entries[AW-1:0] + i_rd_idx;
    assign w_rd_ok    = ({1'b0, i_rd_idx} < r_entries) && (int'(i_rd_ch) < NUM_CH);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_entries     <= '0;
            r_cycle_count <= '0;
            r_post_cnt    <= '0;
            r_limit_hit   <= 1'b0;
        end else if (i_arm) begin
            r_state       <= S_ARMED;
            r_wr_ptr      <= '0;
            r_entries     <= '0;
            r_cycle_count <= '0;
            r_post_cnt    <= '0;
            r_limit_hit   <= 1'b0;
        end else if (w_capture) begin
            r_wr_ptr      <= r_wr_ptr + 1'b1;
            r_cycle_count <= w_cnt_next;
            if (r_entries != (AW+1)'(DEPTH))
                r_entries <= r_entries + 1'b1;
            if (w_limit) begin
                r_state     <= S_DONE;
                r_limit_hit <= 1'b1;
            end else if (r_state == S_ARMED) begin
                if (i_trig) begin
                    r_post_cnt <= PW'(POST_TRIG);
                    r_state    <= (POST_TRIG == 0) ? S_DONE : S_POST;
                end
            end else begin
                r_post_cnt <= r_post_cnt - 1'b1;
                if (r_post_cnt == PW'(1))
                    r_state <= S_DONE;
            end
        end
    end

    // Storage is never cleared; entries gates what is readable
    always_ff @(posedge i_clock) begin
        if (w_capture && !i_reset) begin
            for (int c = 0; c < NUM_CH; c++)
                r_mem[r_wr_ptr][c] <= i_ch_mask[c] ? i_ch_data[c*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en)
                r_rd_data <= w_rd_ok ? r_mem[w_rd_slot][i_rd_ch] : '0;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [CNT_WIDTH-1:0] r_ts_mem [DEPTH];
    logic [CNT_WIDTH-1:0] r_rd_ts;

    always_ff @(posedge i_clock) begin
        if (w_capture && !i_reset)
            r_ts_mem[r_wr_ptr] <= w_cnt_next;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_rd_ts <= '0;
        else if (i_rd_en)
            r_rd_ts <= w_rd_ok ? r_ts_mem[w_rd_slot] : '0;
    end

    assign o_rd_ts = r_rd_ts;
`else
    assign o_rd_ts = '0;
`endif

    assign o_state       = r_state;
    assign o_done        = (r_state == S_DONE);
    assign o_limit_hit   = r_limit_hit;
    assign o_cycle_count = r_cycle_count;
    assign o_entries     = r_entries;
    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer: default instance plus a CYCLE_LIMIT=5 instance sharing stimulus.
module tb_pipe_trace_buffer;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int DP = 16;
    localparam int TW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            arm;
    logic            trig;
    logic [NC*DW-1:0] ch_data;
    logic [NC-1:0]   ch_mask;
    logic            rd_en;
    logic [3:0]      rd_idx;
    logic [1:0]      rd_ch;

    logic [1:0]      a_state, b_state;
    logic            a_done, b_done, a_lim, b_lim, a_vld, b_vld;
    logic [TW-1:0]   a_cc, b_cc, a_ts, b_ts;
    logic [4:0]      a_ent, b_ent;
    logic [DW-1:0]   a_rd, b_rd;

    always #5 clk = ~clk;

    pipe_trace_buffer u_dut_a (
        .i_clock(clk), .i_reset(rst), .i_arm(arm), .i_trig(trig),
        .i_ch_data(ch_data), .i_ch_mask(ch_mask),
        .o_state(a_state), .o_done(a_done), .o_limit_hit(a_lim),
        .o_cycle_count(a_cc), .o_entries(a_ent),
        .i_rd_en(rd_en), .i_rd_idx(rd_idx), .i_rd_ch(rd_ch),
        .o_rd_data(a_rd), .o_rd_ts(a_ts), .o_rd_valid(a_vld)
    );

    pipe_trace_buffer #(.CYCLE_LIMIT(5)) u_dut_b (
        .i_clock(clk), .i_reset(rst), .i_arm(arm), .i_trig(trig),
        .i_ch_data(ch_data), .i_ch_mask(ch_mask),
        .o_state(b_state), .o_done(b_done), .o_limit_hit(b_lim),
        .o_cycle_count(b_cc), .o_entries(b_ent),
        .i_rd_en(rd_en), .i_rd_idx(rd_idx), .i_rd_ch(rd_ch),
        .o_rd_data(b_rd), .o_rd_ts(b_ts), .o_rd_valid(b_vld)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] ts;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cap;
    int trig_at;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] exp_ts(input int v);
`ifdef TRACE_TIMESTAMP_EN
        return TW'(v);
`else
        return '0;
`endif
    endfunction

    always @(negedge clk) begin
        if (a_vld) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_rd_valid", 1, 0);
            end else begin
                rd_exp_t e;
                e = sb_q.pop_front();
                check_val("rd_data", a_rd, e.d);
                check_val("rd_ts", a_ts, e.ts);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input int c);
        ch_data = {DW'(c + 300), DW'(c + 200), DW'(c + 100), DW'(c)};
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cap = 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_sample(cap);
            trig = (cap == trig_at);
            tick();
            cap++;
        end
        trig = 1'b0;
    endtask

    task automatic rd(input int idx, input int ch, input logic [DW-1:0] d, input logic [TW-1:0] ts);
        rd_exp_t e;
        rd_en  = 1'b1;
        rd_idx = 4'(idx);
        rd_ch  = 2'(ch);
        e.d = d;
        e.ts = ts;
        sb_q.push_back(e);
        tick();
    endtask

    task automatic rd_stop();
        rd_en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; arm = 1'b0; trig = 1'b0; ch_data = '0; ch_mask = '1;
        rd_en = 1'b0; rd_idx = '0; rd_ch = '0; cap = 0; trig_at = 0;
        tick(); tick();
        rst = 1'b0;
        repeat (10) tick();
        check_val("reset_state", a_state, 0);
        check_val("reset_entries", a_ent, 0);
        check_val("reset_done", a_done, 0);
        check_val("reset_cycle_count", a_cc, 0);
        check_val("reset_limit_hit", a_lim, 0);

        // trigger run: trig at capture 10, eight post samples
        do_arm();
        check_val("arm_state", a_state, 1);
        trig_at = 10;
        run(17);
        check_val("post_state", a_state, 2);
        check_val("post_done", a_done, 0);
        run(1);
        check_val("trig_done", a_done, 1);
        check_val("trig_state", a_state, 3);
        check_val("trig_entries", a_ent, 16);
        check_val("trig_cycle_count", a_cc, 18);
        check_val("trig_limit_hit", a_lim, 0);
        run(3);
        check_val("frozen_entries", a_ent, 16);
        check_val("frozen_cycle_count", a_cc, 18);
        for (int i = 0; i < DP; i++)
            rd(i, 0, DW'(i + 3), exp_ts(i + 3));
        rd(4, 2, DW'(207), exp_ts(7));
        rd_stop();

        // limit run: no trigger, stops at capture 20
        do_arm();
        trig_at = 0;
        run(19);
        check_val("prelimit_state", a_state, 1);
        check_val("prelimit_limit_hit", a_lim, 0);
        run(1);
        check_val("limit_state", a_state, 3);
        check_val("limit_hit", a_lim, 1);
        check_val("limit_entries", a_ent, 16);
        check_val("limit_cycle_count", a_cc, 20);
        rd(0, 0, DW'(5), exp_ts(5));
        rd(15, 0, DW'(20), exp_ts(20));
        rd(7, 1, DW'(112), exp_ts(12));
        rd_stop();

        // trig and limit in the same capture on the CYCLE_LIMIT=5 instance
        do_arm();
        trig_at = 5;
        run(5);
        check_val("b_same_state", b_state, 3);
        check_val("b_same_limit_hit", b_lim, 1);
        check_val("b_same_entries", b_ent, 5);
        check_val("a_trig5_state", a_state, 2);

        // re-arm with trig asserted in the same cycle
        arm = 1'b1;
        trig = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b0;
        check_val("rearm_state", a_state, 1);
        check_val("rearm_entries", a_ent, 0);
        check_val("rearm_limit_hit", a_lim, 0);
        check_val("rearm_cycle_count", a_cc, 0);
        check_val("b_rearm_state", b_state, 1);
        check_val("b_rearm_limit_hit", b_lim, 0);
        rd(0, 0, '0, '0);
        rd_en = 1'b0;
        check_val("rearm_still_armed", a_state, 1);
        check_val("rearm_one_capture", a_ent, 1);
        tick(); tick();

        // masked channels 1 and 3
        ch_mask = 4'b0101;
        do_arm();
        trig_at = 1;
        run(9);
        check_val("mask_done", a_done, 1);
        check_val("mask_entries", a_ent, 9);
        ch_mask = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (i < 9)
                    rd(i, c, (c % 2 == 0) ? DW'(i + 1 + 100 * c) : '0, exp_ts(i + 1));
                else
                    rd(i, c, '0, '0);
            end
        end
        rd_stop();

        // reset in the middle of a capture
        do_arm();
        run(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_state", a_state, 0);
        check_val("midrst_entries", a_ent, 0);
        check_val("midrst_cycle_count", a_cc, 0);
        run(2);
        check_val("midrst_idle", a_state, 0);

        tick(); tick();
        check_val("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
